// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command/response layer.
// Imported by the assembler top and the response transmitter.
package uart_cmd_pkg;

    typedef enum logic {
        RX_IDLE,
        RX_WAIT_LO
    } rx_state_t;

    typedef enum logic {
        TX_IDLE,
        TX_BUSY
    } tx_state_t;

    localparam int CMD_BYTES = 2;
    localparam int BYTE_W    = 8;

    // Bits needed to count 0 .. timeout-1.
    function automatic int tmr_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/uart_resp_tx.sv
// Single-byte response transmitter with a one-deep pending buffer.
// Issues trmt strobes and reports completion or dropped requests.
module uart_resp_tx
    import uart_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       send_resp,
    input  logic [7:0] resp,
    output logic       trmt,
    output logic [7:0] tx_data,
    input  logic       tx_done,
    output logic       resp_sent,
    output logic       resp_drop
);

    tx_state_t  r_state;
    tx_state_t  w_state_nxt;
    logic       r_trmt;
    logic [7:0] r_tx_data;
    logic       r_sent;
    logic       r_drop;
    logic       r_pend_vld;
    logic [7:0] r_pend;

    logic       w_issue;
    logic [7:0] w_issue_byte;
    logic       w_pend_load;
    logic       w_pend_clr;
    logic       w_sent;
    logic       w_drop;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= TX_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, issue selection and pending-buffer control.
    always_comb begin
        w_state_nxt  = r_state;
        w_issue      = 1'b0;
        w_issue_byte = r_pend;
        w_pend_load  = 1'b0;
        w_pend_clr   = 1'b0;
        w_sent       = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            TX_IDLE: begin
                if (r_pend_vld) begin
                    w_issue      = 1'b1;
                    w_issue_byte = r_pend;
                    w_state_nxt  = TX_BUSY;
                    if (send_resp) begin
                        w_pend_load = 1'b1;
                    end else begin
                        w_pend_clr  = 1'b1;
                    end
                end else if (send_resp) begin
                    w_issue      = 1'b1;
                    w_issue_byte = resp;
                    w_state_nxt  = TX_BUSY;
                end
            end
            TX_BUSY: begin
                // tx_done is stale while our own strobe is still out.
                if (tx_done && !r_trmt) begin
                    w_sent      = 1'b1;
                    w_state_nxt = TX_IDLE;
                end
                if (send_resp) begin
                    if (r_pend_vld) begin
                        w_drop = 1'b1;
                    end else begin
                        w_pend_load = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = TX_IDLE;
            end
        endcase
    end

    // Output strobes, transmit byte and pending buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_trmt     <= 1'b0;
            r_tx_data  <= 8'h00;
            r_sent     <= 1'b0;
            r_drop     <= 1'b0;
            r_pend_vld <= 1'b0;
            r_pend     <= 8'h00;
        end else begin
            r_trmt <= w_issue;
            r_sent <= w_sent;
            r_drop <= w_drop;
            if (w_issue) begin
                r_tx_data <= w_issue_byte;
            end
            if (w_pend_load) begin
                r_pend     <= resp;
                r_pend_vld <= 1'b1;
            end else if (w_pend_clr) begin
                r_pend_vld <= 1'b0;
            end
        end
    end

    assign trmt      = r_trmt;
    assign tx_data   = r_tx_data;
    assign resp_sent = r_sent;
    assign resp_drop = r_drop;

endmodule

// File: rtl/uart_cmd_assembler.sv
// Assembles two received bytes into a 16-bit command with timeout,
// and forwards single-byte responses to the UART transmitter.
module uart_cmd_assembler
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT = 100000,
    parameter int CMD_W   = CMD_BYTES * BYTE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_rdy,
    input  logic [7:0]       rx_data,
    output logic             clr_rx_rdy,
    output logic             cmd_rdy,
    output logic [CMD_W-1:0] cmd,
    input  logic             clr_cmd_rdy,
    output logic             frame_err,
    input  logic             send_resp,
    input  logic [7:0]       resp,
    output logic             trmt,
    output logic [7:0]       tx_data,
    input  logic             tx_done,
    output logic             resp_sent,
    output logic             resp_drop
);

    localparam int TW = tmr_width(TIMEOUT);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

    rx_state_t        r_rx_state;
    rx_state_t        w_rx_state_nxt;
    logic [7:0]       r_hi;
    logic [TW-1:0]    r_tmr;
    logic [CMD_W-1:0] r_cmd;
    logic             r_cmd_rdy;
    logic             r_frame_err;

    logic             w_acc_hi;
    logic             w_acc_lo;
    logic             w_tmo;

    // RX state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state <= RX_IDLE;
        end else begin
            r_rx_state <= w_rx_state_nxt;
        end
    end

    // RX next state; a byte arriving on the timeout cycle wins.
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_acc_hi       = 1'b0;
        w_acc_lo       = 1'b0;
        w_tmo          = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (rx_rdy) begin
                    w_acc_hi       = 1'b1;
                    w_rx_state_nxt = RX_WAIT_LO;
                end
            end
            RX_WAIT_LO: begin
                if (rx_rdy) begin
                    w_acc_lo       = 1'b1;
                    w_rx_state_nxt = RX_IDLE;
                end else if (r_tmr == TMR_LAST) begin
                    w_tmo          = 1'b1;
                    w_rx_state_nxt = RX_IDLE;
                end
            end
            default: begin
                w_rx_state_nxt = RX_IDLE;
            end
        endcase
    end

    assign clr_rx_rdy = (w_acc_hi | w_acc_lo) & ~rst;

    // High byte, inter-byte timer, command and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi        <= 8'h00;
            r_tmr       <= '0;
            r_cmd       <= '0;
            r_cmd_rdy   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_tmo;
            if (w_acc_hi) begin
                r_hi  <= rx_data;
                r_tmr <= '0;
            end else if (r_rx_state == RX_WAIT_LO) begin
                r_tmr <= r_tmr + TW'(1);
            end
            if (w_acc_lo) begin
                r_cmd <= {r_hi, rx_data};
            end
            if (w_acc_lo) begin
                r_cmd_rdy <= 1'b1;
            end else if (w_acc_hi || clr_cmd_rdy) begin
                r_cmd_rdy <= 1'b0;
            end
        end
    end

    assign cmd       = r_cmd;
    assign cmd_rdy   = r_cmd_rdy;
    assign frame_err = r_frame_err;

    uart_resp_tx u_resp_tx (
        .clk       (clk),
        .rst       (rst),
        .send_resp (send_resp),
        .resp      (resp),
        .trmt      (trmt),
        .tx_data   (tx_data),
        .tx_done   (tx_done),
        .resp_sent (resp_sent),
        .resp_drop (resp_drop)
    );

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Bench for uart_cmd_assembler: directed scenarios then random traffic,
// every cycle compared against an event-level reference model.
module tb_uart_cmd_assembler;

    localparam int T = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_rdy = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        clr_rx_rdy;
    logic        cmd_rdy;
    logic [15:0] cmd;
    logic        clr_cmd_rdy = 1'b0;
    logic        frame_err;
    logic        send_resp = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        tx_done = 1'b0;
    logic        resp_sent;
    logic        resp_drop;

    always #5 clk = ~clk;

    uart_cmd_assembler #(.TIMEOUT(T)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_rdy      (rx_rdy),
        .rx_data     (rx_data),
        .clr_rx_rdy  (clr_rx_rdy),
        .cmd_rdy     (cmd_rdy),
        .cmd         (cmd),
        .clr_cmd_rdy (clr_cmd_rdy),
        .frame_err   (frame_err),
        .send_resp   (send_resp),
        .resp        (resp),
        .trmt        (trmt),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .resp_sent   (resp_sent),
        .resp_drop   (resp_drop)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // Requested inputs for the next cycle.
    logic       d_rst = 1'b1;
    logic       d_rx = 1'b0;
    logic       d_clr = 1'b0;
    logic       d_send = 1'b0;
    logic [7:0] d_rx_data = 8'h00;
    logic [7:0] d_resp = 8'h00;

    // Transmitter environment.
    int   tx_dur = 20;
    int   tx_cnt = 0;
    logic prev_trmt = 1'b0;

    // Reference model state and expectations.
    logic        m_hi_vld = 1'b0;
    logic [7:0]  m_hi = 8'h00;
    int          m_hi_cyc = 0;
    logic        m_fly = 1'b0;
    int          m_fly_cyc = 0;
    logic [7:0]  m_pend[$];
    logic [15:0] e_cmd = 16'h0000;
    logic        e_cmd_rdy = 1'b0;
    logic        e_fe = 1'b0;
    logic        e_trmt = 1'b0;
    logic [7:0]  e_tx_data = 8'h00;
    logic        e_sent = 1'b0;
    logic        e_drop = 1'b0;
    logic        e_clr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // Apply the cycle's inputs to the model; expectations are for the
    // registered outputs seen in the following cycle.
    task automatic model_cycle();
        e_fe   = 1'b0;
        e_trmt = 1'b0;
        e_sent = 1'b0;
        e_drop = 1'b0;
        e_clr  = rx_rdy && !rst;
        if (rst) begin
            e_cmd     = 16'h0000;
            e_cmd_rdy = 1'b0;
            e_tx_data = 8'h00;
            m_hi_vld  = 1'b0;
            m_fly     = 1'b0;
            m_pend.delete();
            return;
        end
        if (rx_rdy) begin
            if (m_hi_vld && (cyc - m_hi_cyc) <= T) begin
                e_cmd     = {m_hi, rx_data};
                e_cmd_rdy = 1'b1;
                m_hi_vld  = 1'b0;
            end else begin
                m_hi_vld  = 1'b1;
                m_hi      = rx_data;
                m_hi_cyc  = cyc;
                e_cmd_rdy = 1'b0;
            end
        end else begin
            if (clr_cmd_rdy) e_cmd_rdy = 1'b0;
            if (m_hi_vld && (cyc - m_hi_cyc) == T) begin
                e_fe     = 1'b1;
                m_hi_vld = 1'b0;
            end
        end
        if (!m_fly) begin
            if (m_pend.size() > 0) begin
                e_trmt    = 1'b1;
                e_tx_data = m_pend.pop_front();
                m_fly     = 1'b1;
                m_fly_cyc = cyc;
                if (send_resp) m_pend.push_back(resp);
            end else if (send_resp) begin
                e_trmt    = 1'b1;
                e_tx_data = resp;
                m_fly     = 1'b1;
                m_fly_cyc = cyc;
            end
        end else begin
            // done only counts once the strobe has reached the transmitter
            if (tx_done && cyc > m_fly_cyc + 1) begin
                e_sent = 1'b1;
                m_fly  = 1'b0;
            end
            if (send_resp) begin
                if (m_pend.size() >= 1) e_drop = 1'b1;
                else m_pend.push_back(resp);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        chk("cmd_rdy", 32'(cmd_rdy), 32'(e_cmd_rdy));
        chk("cmd", 32'(cmd), 32'(e_cmd));
        chk("frame_err", 32'(frame_err), 32'(e_fe));
        chk("trmt", 32'(trmt), 32'(e_trmt));
        chk("tx_data", 32'(tx_data), 32'(e_tx_data));
        chk("resp_sent", 32'(resp_sent), 32'(e_sent));
        chk("resp_drop", 32'(resp_drop), 32'(e_drop));
        if (prev_trmt) begin
            tx_done = 1'b0;
            tx_cnt  = tx_dur;
        end else if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) tx_done = 1'b1;
        end
        prev_trmt   = trmt;
        rst         = d_rst;
        rx_rdy      = d_rx;
        rx_data     = d_rx_data;
        clr_cmd_rdy = d_clr;
        send_resp   = d_send;
        resp        = d_resp;
        model_cycle();
        #1;
        chk("clr_rx_rdy", 32'(clr_rx_rdy), 32'(e_clr));
        d_rx   = 1'b0;
        d_clr  = 1'b0;
        d_send = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        d_rx      = 1'b1;
        d_rx_data = b;
        tick();
    endtask

    task automatic req_resp(input logic [7:0] b);
        d_send = 1'b1;
        d_resp = b;
        tick();
    endtask

    task automatic wait_sent(input string tag, input int budget);
        int k;
        k = 0;
        while (resp_sent !== 1'b1 && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 32'(resp_sent), 32'h1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int quiet;
        int n_sent;
        repeat (2) @(posedge clk);

        // reset
        d_rst = 1'b1;
        idle(2);
        d_rst = 1'b0;
        chk("rst_cmd", 32'(cmd), 32'h0);
        chk("rst_cmd_rdy", 32'(cmd_rdy), 32'h0);
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        chk("rst_trmt", 32'(trmt), 32'h0);

        // basic two-byte frame, then consumer acknowledge
        send_byte(8'hA5);
        idle(9);
        send_byte(8'h3C);
        idle(1);
        chk("t1_cmd", 32'(cmd), 32'h0000A53C);
        chk("t1_rdy", 32'(cmd_rdy), 32'h1);
        d_clr = 1'b1;
        tick();
        idle(1);
        chk("t1_clr", 32'(cmd_rdy), 32'h0);

        // orphaned high byte times out
        send_byte(8'h12);
        idle(T);
        chk("t2_fe_early", 32'(frame_err), 32'h0);
        idle(1);
        chk("t2_fe", 32'(frame_err), 32'h1);
        idle(1);
        chk("t2_fe_pulse", 32'(frame_err), 32'h0);
        send_byte(8'h34);
        idle(2);
        send_byte(8'h56);
        idle(1);
        chk("t2_cmd", 32'(cmd), 32'h00003456);

        // low byte on the last allowed cycle wins over timeout
        send_byte(8'hC0);
        idle(T - 1);
        send_byte(8'hDE);
        idle(1);
        chk("t2_edge_fe", 32'(frame_err), 32'h0);
        chk("t2_edge_cmd", 32'(cmd), 32'h0000C0DE);

        // new high byte clears cmd_rdy; set beats clr
        send_byte(8'hA5);
        send_byte(8'h3C);
        idle(1);
        send_byte(8'hFF);
        idle(1);
        chk("t3_drop_rdy", 32'(cmd_rdy), 32'h0);
        chk("t3_hold_cmd", 32'(cmd), 32'h0000A53C);
        d_clr = 1'b1;
        send_byte(8'h00);
        idle(1);
        chk("t3_cmd", 32'(cmd), 32'h0000FF00);
        chk("t3_set_wins", 32'(cmd_rdy), 32'h1);

        // single response
        tx_dur = 20;
        req_resp(8'hA5);
        idle(1);
        chk("t4_trmt", 32'(trmt), 32'h1);
        chk("t4_tx_data", 32'(tx_data), 32'h000000A5);
        wait_sent("t4_sent", 40);

        // pending buffer and drop
        req_resp(8'h77);
        idle(2);
        req_resp(8'h0A);
        req_resp(8'h0B);
        idle(1);
        chk("t5_drop", 32'(resp_drop), 32'h1);
        wait_sent("t5_sent", 40);
        idle(1);
        chk("t5_trmt", 32'(trmt), 32'h1);
        chk("t5_tx_data", 32'(tx_data), 32'h0000000A);
        wait_sent("t5_sent2", 40);

        // reset mid-frame and mid-transmit
        send_byte(8'h77);
        req_resp(8'h99);
        idle(3);
        d_rst = 1'b1;
        idle(2);
        d_rst = 1'b0;
        chk("t6_cmd", 32'(cmd), 32'h0);
        chk("t6_rdy", 32'(cmd_rdy), 32'h0);
        chk("t6_tx_data", 32'(tx_data), 32'h0);
        chk("t6_trmt", 32'(trmt), 32'h0);
        chk("t6_clr", 32'(clr_rx_rdy), 32'h0);
        n_sent = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (resp_sent === 1'b1) n_sent++;
        end
        chk("t6_no_sent", 32'(n_sent), 32'h0);
        send_byte(8'h11);
        send_byte(8'h22);
        idle(1);
        chk("t6_cmd_new", 32'(cmd), 32'h00001122);

        // random traffic
        quiet = 0;
        for (int i = 0; i < 4000; i++) begin
            if (quiet > 0) begin
                quiet--;
            end else begin
                if ($urandom_range(0, 199) == 0) quiet = $urandom_range(40, 70);
                d_rx      = ($urandom_range(0, 5) == 0);
                d_rx_data = 8'($urandom);
            end
            d_send = ($urandom_range(0, 7) == 0);
            d_resp = 8'($urandom);
            d_clr  = ($urandom_range(0, 9) == 0);
            d_rst  = ($urandom_range(0, 599) == 0);
            tx_dur = $urandom_range(2, 25);
            tick();
        end
        d_rst = 1'b0;
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
